// File: rtl/pc_stack_counter.sv
// pc_stack_counter: parametrised program counter with signed relative branch
// and a hardware return-address stack (call/ret) with full/empty/sticky error.
module pc_stack_counter #(
  parameter int WIDTH = 8,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VAL = 0,
  localparam int SPW = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             branch,
  input  logic [WIDTH-1:0] offset,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [SPW-1:0]   sp,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             err
);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  logic [WIDTH-1:0] stack [STACK_DEPTH];
  logic [WIDTH-1:0] pc_next, pc_inc;
  logic [SPW-1:0] sp_dec;
  logic do_load, do_call, do_ret, do_br, do_step, do_inc, do_dec, push, pop, fault;
  assign stack_full  = sp == SPW'(STACK_DEPTH);
  assign stack_empty = sp == '0;
  assign pc_inc = pc + 1'b1;
  assign sp_dec = sp - 1'b1;
  // Strict priority: load > call > ret > branch > inc/dec.
  assign do_load = enable & load;
  assign do_call = enable & ~load & call;
  assign do_ret  = enable & ~load & ~call & ret;
  assign do_br   = enable & ~load & ~call & ~ret & branch;
  assign do_step = enable & ~load & ~call & ~ret & ~branch;
  assign do_inc  = do_step & inc & ~dec;
  assign do_dec  = do_step & dec & ~inc;
  assign push  = do_call & ~stack_full;
  assign pop   = do_ret & ~stack_empty;
  assign fault = (do_call & stack_full) | (do_ret & stack_empty);
  always_comb begin
    pc_next = (do_load | push) ? load_val :
              pop    ? stack[sp_dec[AW-1:0]] :
              do_br  ? pc + offset :
              do_inc ? pc_inc :
              do_dec ? pc - 1'b1 : pc;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc  <= WIDTH'(RESET_VAL);
      sp  <= '0;
      err <= 1'b0;
    end else begin
      pc <= pc_next;
      if (push) sp <= sp + 1'b1;
      else if (pop) sp <= sp_dec;
      if (fault) err <= 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (push) stack[sp[AW-1:0]] <= pc_inc;
  end
endmodule
